show_state: RTL and testbench
=============================

Name: show_state

Overview:
- Playback reader for the Simon Says game; the counterpart to the idle/load stage that writes the LFSR colour sequence into sequence memory.
- When enabled, it reads entries 0..N-1 from the 4-entry sequence memory, decodes each byte to one of four colour LEDs, and drives each LED for a fixed on-time followed by an off-gap.
- It raises a completion flag when the last entry has been shown, so the top-level FSM can advance to the input-capture stage.

Parameters:
- ON_CYCLES, 8, clock cycles each LED is lit (legal range 1..2^CNT_W-1).
- OFF_CYCLES, 4, clock cycles of dark gap after each LED (legal range 1..2^CNT_W-1).
- CNT_W, 8, width of the internal duration counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_SHOW  input  1  reset, asynchronous, active-high.
- en_SHOW  input  1  stage enable; while low, all state and outputs hold.
- round_len  input  3  number of entries to show, sampled on leaving S_IDLE.
- MEM_OUT  input  8  sequence memory read data, valid 1 cycle after the MEM_READ strobe.
- MEM_READ  output  1  one-cycle read strobe to sequence memory.
- MEM_READ_VAL  output  2  read address, 0..3.
- LED  output  4  one-hot colour drive; 0 = dark.
- complete_SHOW  output  1  high once playback has finished; holds until reset.

Behaviour:
- Reset (asynchronous, takes effect immediately at any point, including mid-playback):
  - MEM_READ=0, MEM_READ_VAL=0, LED=0, complete_SHOW=0.
  - Index=0, duration counter=0, state=S_IDLE.
- en_SHOW=0: no register changes in any state; outputs hold their current values, so a lit LED stays lit.
- round_len clamping, applied when sampled: 0 -> 1; 5..7 -> 4; 1..4 used as-is. last = clamped value - 1.
- States and transitions (all evaluated only while en_SHOW=1):
  - S_IDLE -> S_READ. Latch last; index=0.
  - S_READ (1 cycle): MEM_READ=1, MEM_READ_VAL=index, LED=0 -> S_WAIT.
  - S_WAIT (1 cycle): MEM_READ=0. Capture MEM_OUT[1:0] and set LED = 4'b0001 << MEM_OUT[1:0]. MEM_OUT[7:2] are ignored. Load counter=ON_CYCLES-1 -> S_ON.
  - S_ON: LED holds. Counter decrements each cycle. At counter==0: LED=0, counter=OFF_CYCLES-1 -> S_OFF.
  - S_OFF: LED=0. Counter decrements each cycle. At counter==0:
    - if index==last -> S_DONE, with complete_SHOW=1 in the same edge;
    - otherwise index+1 -> S_READ.
  - S_DONE: terminal. complete_SHOW=1, LED=0, MEM_READ=0. Leaves only via rst_SHOW.
- Timing:
  - LED turns on 2 cycles after the edge that left S_IDLE.
  - Each entry occupies exactly 2 + ON_CYCLES + OFF_CYCLES enabled cycles.
  - The LED is lit for exactly ON_CYCLES enabled cycles.
- Invariants:
  - Index never exceeds 3, so MEM_READ_VAL never wraps.
  - MEM_READ is never high for two consecutive cycles.
  - At most one LED bit is set at any time.
- Pausing: deasserting en_SHOW during S_ON or S_OFF freezes the counter. Re-enabling resumes with the remaining duration unchanged.
- Mid-run round_len changes have no effect; the value is sampled only on leaving S_IDLE.

Test Plan:
- Basic two-entry playback (ON=3, OFF=2; memory[0]=0x02, memory[1]=0xFD; round_len=2; en_SHOW=1):
  - MEM_READ pulses with addr 0, then addr 1, 7 cycles apart.
  - LED=0100 for 3 cycles, dark 2 cycles, LED=0010 for 3 cycles, dark 2 cycles.
  - complete_SHOW rises 14 cycles after leaving S_IDLE.
- round_len clamping: round_len=0 -> exactly one read (addr 0). round_len=7 -> four reads (addr 0,1,2,3), then complete_SHOW=1 with no fifth read.
- Pause: drop en_SHOW for 5 cycles during the 2nd ON cycle. LED stays lit throughout the pause; after re-enable it stays lit exactly 2 more cycles.
- Async reset mid-operation: assert rst_SHOW between clock edges while in S_ON. LED, MEM_READ and complete_SHOW go 0 immediately, before the next edge. After release with en_SHOW=1, playback restarts from addr 0.
- Terminal state: after complete_SHOW=1, run 20 more cycles with en_SHOW=1 and change round_len. No further MEM_READ pulses, LED=0, complete_SHOW stays 1.
- Decode sweep: memory = 0x00, 0x01, 0x02, 0x03 with round_len=4 gives LED 0001, 0010, 0100, 1000 in order; LED is one-hot or zero on every cycle.

Source files
------------

// File: rtl/show_state.sv
// Simon Says playback: reads entries 0..last from sequence memory and flashes each colour LED.
// Each entry takes 2+ON_CYCLES+OFF_CYCLES enabled cycles; en_SHOW low freezes every register.
module show_state #(
    parameter int ON_CYCLES  = 8,
    parameter int OFF_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_SHOW,
    input  logic       en_SHOW,
    input  logic [2:0] round_len,
    input  logic [7:0] MEM_OUT,
    output logic       MEM_READ,
    output logic [1:0] MEM_READ_VAL,
    output logic [3:0] LED,
    output logic       complete_SHOW
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_ON, S_OFF, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

    state_t           state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [1:0]       last, last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       last_clamped;
    logic             mem_read_nxt;
    logic [1:0]       addr_nxt;
    logic [3:0]       led_nxt;
    logic             complete_nxt;

    // round_len 0 still shows one entry; anything above 4 saturates at the memory depth.
    always_comb begin
        case (round_len)
            3'd0, 3'd1: last_clamped = 2'd0;
            3'd2:       last_clamped = 2'd1;
            3'd3:       last_clamped = 2'd2;
            default:    last_clamped = 2'd3;
        endcase
    end

    always_ff @(posedge clk or posedge rst_SHOW) begin
        if (rst_SHOW) begin
            state         <= S_IDLE;
            idx           <= 2'd0;
            last          <= 2'd0;
            cnt           <= '0;
            MEM_READ      <= 1'b0;
            MEM_READ_VAL  <= 2'd0;
            LED           <= 4'd0;
            complete_SHOW <= 1'b0;
        end else if (en_SHOW) begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            last          <= last_nxt;
            cnt           <= cnt_nxt;
            MEM_READ      <= mem_read_nxt;
            MEM_READ_VAL  <= addr_nxt;
            LED           <= led_nxt;
            complete_SHOW <= complete_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        last_nxt  = last;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                state_nxt = S_READ;
                last_nxt  = last_clamped;
                idx_nxt   = 2'd0;
            end
            S_READ: state_nxt = S_WAIT;
            S_WAIT: begin
                cnt_nxt   = ON_LOAD;
                state_nxt = S_ON;
            end
            S_ON: begin
                if (cnt == '0) begin
                    cnt_nxt   = OFF_LOAD;
                    state_nxt = S_OFF;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_OFF: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (idx == last) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt   = idx + 2'd1;
                    state_nxt = S_READ;
                end
            end
            default: state_nxt = S_DONE;
        endcase
    end

    // Outputs are registered: these are the values loaded on the next enabled edge.
    always_comb begin
        mem_read_nxt = 1'b0;
        addr_nxt     = MEM_READ_VAL;
        led_nxt      = LED;
        complete_nxt = complete_SHOW;
        case (state)
            S_IDLE: begin
                mem_read_nxt = 1'b1;
                addr_nxt     = 2'd0;
                led_nxt      = 4'd0;
            end
            S_READ: led_nxt = 4'd0;
            S_WAIT: led_nxt = 4'b0001 << MEM_OUT[1:0];
            S_ON: begin
                if (cnt == '0)
                    led_nxt = 4'd0;
            end
            S_OFF: begin
                led_nxt = 4'd0;
                if (cnt == '0) begin
                    if (idx == last) begin
                        complete_nxt = 1'b1;
                    end else begin
                        mem_read_nxt = 1'b1;
                        addr_nxt     = idx + 2'd1;
                    end
                end
            end
            default: begin
                led_nxt      = 4'd0;
                complete_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_show_state.sv
// Directed bench for show_state with ON=3, OFF=2 and a synchronous-read memory model.
module tb_show_state;

    localparam int ON  = 3;
    localparam int OFF = 2;

    logic       clk = 1'b0;
    logic       rst_SHOW = 1'b1;
    logic       en_SHOW = 1'b0;
    logic [2:0] round_len = 3'd0;
    logic [7:0] MEM_OUT;
    logic       MEM_READ;
    logic [1:0] MEM_READ_VAL;
    logic [3:0] LED;
    logic       complete_SHOW;

    logic [7:0] mem [4];
    int n_vec = 0;
    int n_bad = 0;

    int         nreads, nled, oh_bad, b2b;
    logic [1:0] addrs [8];
    logic [3:0] leds [8];
    logic       prev_rd;
    logic [3:0] prev_led;
    logic [3:0] exp_led [16];

    show_state #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .CNT_W(8)) dut (
        .clk(clk), .rst_SHOW(rst_SHOW), .en_SHOW(en_SHOW), .round_len(round_len),
        .MEM_OUT(MEM_OUT), .MEM_READ(MEM_READ), .MEM_READ_VAL(MEM_READ_VAL),
        .LED(LED), .complete_SHOW(complete_SHOW)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (MEM_READ) MEM_OUT <= mem[MEM_READ_VAL];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [2:0] rl);
        @(negedge clk);
        rst_SHOW  = 1'b1;
        en_SHOW   = 1'b0;
        round_len = rl;
        @(negedge clk);
        rst_SHOW = 1'b0;
        en_SHOW  = 1'b1;
    endtask

    task automatic capture(input int cycles);
        nreads = 0; nled = 0; oh_bad = 0; b2b = 0;
        prev_rd = 1'b0; prev_led = 4'd0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (MEM_READ) begin
                if (nreads < 8) addrs[nreads] = MEM_READ_VAL;
                nreads++;
                if (prev_rd) b2b++;
            end
            prev_rd = MEM_READ;
            if (LED != 4'd0 && LED != prev_led && nled < 8) begin
                leds[nled] = LED;
                nled++;
            end
            prev_led = LED;
            if (!$onehot0(LED)) oh_bad++;
        end
    endtask

    initial begin
        exp_led = '{4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0,
                    4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};

        // Reset state, then idle hold while disabled
        mem = '{8'h02, 8'hFD, 8'h00, 8'h00};
        repeat (2) @(negedge clk);
        chk("rst_led", LED, 4'h0);
        chk("rst_rd", MEM_READ, 1'b0);
        chk("rst_addr", MEM_READ_VAL, 2'd0);
        chk("rst_cmp", complete_SHOW, 1'b0);
        rst_SHOW = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_hold_rd", MEM_READ, 1'b0);

        // Basic two-entry playback, cycle by cycle
        round_len = 3'd2;
        en_SHOW   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("basic_led%0d", i), LED, exp_led[i]);
            chk($sformatf("basic_rd%0d", i), MEM_READ, (i == 0 || i == 7));
            if (i == 0) chk("basic_addr0", MEM_READ_VAL, 2'd0);
            if (i == 7) chk("basic_addr1", MEM_READ_VAL, 2'd1);
            chk($sformatf("basic_cmp%0d", i), complete_SHOW, (i >= 14));
        end

        // Terminal state ignores round_len changes
        round_len = 3'd5;
        capture(20);
        chk("term_reads", nreads, 0);
        chk("term_led", LED, 4'h0);
        chk("term_cmp", complete_SHOW, 1'b1);

        // round_len=0 clamps to one entry
        mem = '{8'h03, 8'h00, 8'h00, 8'h00};
        start(3'd0);
        capture(20);
        chk("rl0_reads", nreads, 1);
        chk("rl0_addr", addrs[0], 2'd0);
        chk("rl0_led", leds[0], 4'h8);
        chk("rl0_cmp", complete_SHOW, 1'b1);

        // round_len=7 clamps to four entries, no fifth read
        mem = '{8'h01, 8'h02, 8'h03, 8'h00};
        start(3'd7);
        capture(40);
        chk("rl7_reads", nreads, 4);
        for (int a = 0; a < 4; a++) chk($sformatf("rl7_addr%0d", a), addrs[a], a);
        chk("rl7_b2b", b2b, 0);
        chk("rl7_cmp", complete_SHOW, 1'b1);
        capture(10);
        chk("rl7_no5th", nreads, 0);

        // Decode sweep
        mem = '{8'h00, 8'h01, 8'h02, 8'h03};
        start(3'd4);
        capture(40);
        chk("sweep_nled", nled, 4);
        chk("sweep_led0", leds[0], 4'h1);
        chk("sweep_led1", leds[1], 4'h2);
        chk("sweep_led2", leds[2], 4'h4);
        chk("sweep_led3", leds[3], 4'h8);
        chk("sweep_onehot", oh_bad, 0);
        chk("sweep_cmp", complete_SHOW, 1'b1);

        // Pause during the second ON cycle
        mem = '{8'h03, 8'h00, 8'h00, 8'h00};
        start(3'd1);
        repeat (4) @(negedge clk);
        chk("pause_pre", LED, 4'h8);
        en_SHOW = 1'b0;
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            chk($sformatf("pause_led%0d", p), LED, 4'h8);
        end
        en_SHOW = 1'b1;
        @(negedge clk); chk("resume_lit", LED, 4'h8);
        @(negedge clk); chk("resume_dark", LED, 4'h0);
        @(negedge clk); chk("resume_cmp0", complete_SHOW, 1'b0);
        @(negedge clk); chk("resume_cmp1", complete_SHOW, 1'b1);

        // Asynchronous reset while lit
        mem = '{8'h02, 8'h00, 8'h00, 8'h00};
        start(3'd1);
        repeat (3) @(negedge clk);
        chk("arst_pre", LED, 4'h4);
        #2 rst_SHOW = 1'b1;
        #1;
        chk("arst_led", LED, 4'h0);
        chk("arst_rd", MEM_READ, 1'b0);
        chk("arst_cmp", complete_SHOW, 1'b0);
        @(negedge clk);
        rst_SHOW = 1'b0;
        @(negedge clk);
        chk("restart_rd", MEM_READ, 1'b1);
        chk("restart_addr", MEM_READ_VAL, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
